// File: rtl/pbs_battle_datapath.sv
// pbs_battle_datapath
//
// Battle datapath for the Pokemon battle simulator. It sits downstream of the
// battle control FSM. It latches the player's move, draws the AI's move from a
// free-running LFSR, computes damage with a 4-step shift-add multiplier and
// subtracts that damage from the targeted Pokemon's HP, saturating at zero.
//
// Ports:
//   clk            clock
//   reset_n        synchronous active-low reset
//   move_sel       player move select (switches)
//   ld_move        latch move_sel into the player move register
//   calc_damage    level request: compute damage for the active trainer
//   active_trainer 0 = player attacks, 1 = AI attacks
//   target         0 = player Pokemon, 1 = AI Pokemon (sampled at apply)
//   apply_damage   level request: subtract damage from the target's HP (edge-detected)
//   p_hp, ai_hp    HP registers
//   p_fainted      p_hp == 0
//   ai_fainted     ai_hp == 0
//   damage         last computed damage
//   calc_done      high while the calculator is in its DONE state

module pbs_battle_datapath #(
    parameter int unsigned     HP_W      = 8,
    parameter logic [HP_W-1:0] P_MAX_HP  = HP_W'(100),
    parameter logic [HP_W-1:0] AI_MAX_HP = HP_W'(100),
    parameter logic [3:0]      P_ATK     = 4'd5,
    parameter logic [3:0]      AI_ATK    = 4'd4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [1:0]      move_sel,
    input  logic            ld_move,
    input  logic            calc_damage,
    input  logic            active_trainer,
    input  logic            target,
    input  logic            apply_damage,
    output logic [HP_W-1:0] p_hp,
    output logic [HP_W-1:0] ai_hp,
    output logic            p_fainted,
    output logic            ai_fainted,
    output logic [7:0]      damage,
    output logic            calc_done
);

    // Comparison width wide enough for both HP and the 8-bit damage value.
    localparam int unsigned CMP_W = (HP_W > 8) ? HP_W : 8;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDone
    } calc_state_e;

    calc_state_e     state_q, state_d;
    logic [7:0]      lfsr_q, lfsr_d;
    logic [1:0]      pmove_q, pmove_d;
    logic [7:0]      mcand_q, mcand_d;
    logic [3:0]      mplier_q, mplier_d;
    logic [7:0]      acc_q, acc_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [7:0]      damage_q, damage_d;
    logic            apply_prev_q;
    logic [HP_W-1:0] p_hp_q, p_hp_d;
    logic [HP_W-1:0] ai_hp_q, ai_hp_d;

    logic [1:0]      sel_move;
    logic [7:0]      acc_sum;
    logic            apply_edge;
    logic            apply_ok;

    function automatic logic [3:0] move_power(input logic [1:0] mv);
        logic [3:0] pwr;
        unique case (mv)
            2'd0: pwr = 4'd4;
            2'd1: pwr = 4'd6;
            2'd2: pwr = 4'd8;
            2'd3: pwr = 4'd10;
        endcase
        return pwr;
    endfunction

    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                                 input logic [7:0]      dmg);
        logic [CMP_W-1:0] hp_w;
        logic [CMP_W-1:0] dmg_w;
        hp_w  = CMP_W'(hp);
        dmg_w = CMP_W'(dmg);
        return (hp_w > dmg_w) ? HP_W'(hp_w - dmg_w) : '0;
    endfunction

    // Free-running LFSR; the AI move is its low two bits at the start edge.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_comb begin
        pmove_d = ld_move ? move_sel : pmove_q;
    end

    // Calculator FSM and shift-add multiplier.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        damage_d = damage_q;

        sel_move = active_trainer ? lfsr_q[1:0] : pmove_q;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : 8'd0);

        unique case (state_q)
            StIdle: begin
                if (calc_damage) begin
                    mcand_d  = {4'd0, move_power(sel_move)};
                    mplier_d = active_trainer ? AI_ATK : P_ATK;
                    acc_d    = 8'd0;
                    cnt_d    = 2'd0;
                    state_d  = StMul;
                end
            end
            StMul: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    // Final step: include this cycle's partial product before halving.
                    damage_d = {1'b0, acc_sum[7:1]};
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (!calc_damage) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // One subtraction per apply_damage assertion. A rising edge seen during
    // MUL is dropped, but the edge register still advances so it is consumed.
    always_comb begin
        p_hp_d     = p_hp_q;
        ai_hp_d    = ai_hp_q;
        apply_edge = apply_damage & ~apply_prev_q;
        apply_ok   = apply_edge && (state_q != StMul);
        if (apply_ok) begin
            if (target) begin
                ai_hp_d = sat_sub(ai_hp_q, damage_q);
            end else begin
                p_hp_d = sat_sub(p_hp_q, damage_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            lfsr_q       <= 8'hA5;
            pmove_q      <= 2'd0;
            mcand_q      <= 8'd0;
            mplier_q     <= 4'd0;
            acc_q        <= 8'd0;
            cnt_q        <= 2'd0;
            damage_q     <= 8'd0;
            apply_prev_q <= 1'b0;
            p_hp_q       <= P_MAX_HP;
            ai_hp_q      <= AI_MAX_HP;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            pmove_q      <= pmove_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            damage_q     <= damage_d;
            apply_prev_q <= apply_damage;
            p_hp_q       <= p_hp_d;
            ai_hp_q      <= ai_hp_d;
        end
    end

    assign p_hp       = p_hp_q;
    assign ai_hp      = ai_hp_q;
    assign p_fainted  = (p_hp_q == '0);
    assign ai_fainted = (ai_hp_q == '0);
    assign damage     = damage_q;
    assign calc_done  = (state_q == StDone);

endmodule

// File: tb/tb_pbs_battle_datapath.sv
// Self-checking bench for pbs_battle_datapath: directed scenarios followed by
// randomized battles, all compared against a behavioural model of HP, damage
// and the move LFSR.

module tb_pbs_battle_datapath;

    logic       clk;
    logic       reset_n;
    logic [1:0] move_sel;
    logic       ld_move;
    logic       calc_damage;
    logic       active_trainer;
    logic       target;
    logic       apply_damage;
    logic [7:0] p_hp;
    logic [7:0] ai_hp;
    logic       p_fainted;
    logic       ai_fainted;
    logic [7:0] damage;
    logic       calc_done;

    int n_checks = 0;
    int n_errors = 0;
    int edges    = 0;   // non-reset clock edges since the last reset edge
    int p_hp_m, ai_hp_m, dmg_m, pmove_m;

    pbs_battle_datapath dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .move_sel       (move_sel),
        .ld_move        (ld_move),
        .calc_damage    (calc_damage),
        .active_trainer (active_trainer),
        .target         (target),
        .apply_damage   (apply_damage),
        .p_hp           (p_hp),
        .ai_hp          (ai_hp),
        .p_fainted      (p_fainted),
        .ai_fainted     (ai_fainted),
        .damage         (damage),
        .calc_done      (calc_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset_n) edges <= 0;
        else          edges <= edges + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference rules
    function automatic int power_of(input int m);
        return 4 + 2 * m;
    endfunction

    function automatic int dmg_of(input int m, input int trainer);
        return (power_of(m) * ((trainer != 0) ? 4 : 5)) / 2;
    endfunction

    function automatic int sat(input int hp, input int d);
        return (hp > d) ? hp - d : 0;
    endfunction

    // LFSR contents n edges after the seed was loaded.
    function automatic logic [7:0] lfsr_at(input int n);
        logic [7:0] l;
        l = 8'hA5;
        for (int i = 0; i < n; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check_val({tag, "/p_hp"}, 32'(p_hp), 32'(p_hp_m));
        check_val({tag, "/ai_hp"}, 32'(ai_hp), 32'(ai_hp_m));
        check_val({tag, "/p_fainted"}, 32'(p_fainted), 32'(p_hp_m == 0));
        check_val({tag, "/ai_fainted"}, 32'(ai_fainted), 32'(ai_hp_m == 0));
    endtask

    task automatic model_reset();
        p_hp_m  = 100;
        ai_hp_m = 100;
        dmg_m   = 0;
        pmove_m = 0;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        ld_move        = 1'b0;
        calc_damage    = 1'b0;
        apply_damage   = 1'b0;
        active_trainer = 1'b0;
        target         = 1'b0;
        move_sel       = 2'd0;
        tick();
        tick();
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic load_move(input int m);
        move_sel = 2'(m);
        ld_move  = 1'b1;
        tick();
        ld_move  = 1'b0;
        pmove_m  = m;
    endtask

    // Full calculation: checks calc_done timing, damage, and return to idle.
    task automatic do_calc(input int trainer, input int disturb);
        logic [7:0] l;
        int         mv;
        l  = lfsr_at(edges);
        mv = (trainer != 0) ? int'(l[1:0]) : pmove_m;
        active_trainer = (trainer != 0);
        calc_damage    = 1'b1;
        tick();                            // start edge
        if (disturb != 0) begin
            int nm;
            nm       = $urandom_range(0, 3);
            move_sel = 2'(nm);
            ld_move  = 1'b1;
            tick();
            ld_move  = 1'b0;
            pmove_m  = nm;
            tick();
            tick();
        end else begin
            tick();
            tick();
            tick();
        end
        check_val("calc_busy", 32'(calc_done), 0);
        tick();                            // fourth MUL edge
        dmg_m = dmg_of(mv, trainer);
        check_val("calc_done", 32'(calc_done), 1);
        check_val("damage", 32'(damage), 32'(dmg_m));
        calc_damage = 1'b0;
        tick();
        check_val("calc_idle", 32'(calc_done), 0);
    endtask

    task automatic do_apply(input int tgt, input int hold);
        target       = (tgt != 0);
        apply_damage = 1'b1;
        tick();
        if (tgt != 0) ai_hp_m = sat(ai_hp_m, dmg_m);
        else          p_hp_m  = sat(p_hp_m, dmg_m);
        check_state("apply");
        for (int i = 1; i < hold; i++) tick();
        apply_damage = 1'b0;
        tick();
        check_state("apply_hold");
    endtask

    initial begin
        do_reset();
        check_val("rst/damage", 32'(damage), 0);
        check_val("rst/calc_done", 32'(calc_done), 0);
        check_state("rst");

        // AI attack straight out of reset, then hit the player.
        do_calc(1, 0);
        do_apply(0, 1);

        // Player move 3 -> 25; held apply counts once; drain AI to zero.
        do_reset();
        load_move(3);
        do_calc(0, 0);
        check_val("dmg25", 32'(damage), 25);
        do_apply(1, 5);
        check_val("ai_75", 32'(ai_hp), 75);
        for (int i = 0; i < 3; i++) do_apply(1, 1);
        check_val("ai_zero", 32'(ai_hp), 0);
        check_val("ai_fainted_set", 32'(ai_fainted), 1);

        // Saturation with damage 20.
        do_reset();
        load_move(2);
        do_calc(0, 0);
        for (int i = 0; i < 6; i++) do_apply(1, 1);

        // Calc start and apply edge together: apply uses the old damage.
        do_reset();
        load_move(1);
        do_calc(0, 0);
        load_move(3);
        active_trainer = 1'b0;
        target         = 1'b1;
        calc_damage    = 1'b1;
        apply_damage   = 1'b1;
        tick();
        ai_hp_m = sat(ai_hp_m, dmg_m);
        check_state("simul");
        apply_damage = 1'b0;
        tick();
        tick();
        tick();
        check_val("simul_busy", 32'(calc_done), 0);
        tick();
        dmg_m = dmg_of(3, 0);
        check_val("simul_done", 32'(calc_done), 1);
        check_val("simul_damage", 32'(damage), 32'(dmg_m));
        calc_damage = 1'b0;
        tick();

        // Apply edge during MUL is ignored and consumed.
        load_move(0);
        calc_damage = 1'b1;
        tick();
        apply_damage = 1'b1;
        target       = 1'b1;
        tick();
        check_state("mul_apply");
        tick();
        tick();
        tick();
        dmg_m = dmg_of(0, 0);
        check_val("mul_apply_done", 32'(calc_done), 1);
        check_val("mul_apply_damage", 32'(damage), 32'(dmg_m));
        tick();
        check_state("mul_apply_consumed");
        apply_damage = 1'b0;
        calc_damage  = 1'b0;
        tick();
        check_val("mul_apply_idle", 32'(calc_done), 0);
        do_apply(1, 1);

        // Reset during the second MUL cycle.
        calc_damage = 1'b1;
        tick();
        tick();
        reset_n     = 1'b0;
        calc_damage = 1'b0;
        tick();
        model_reset();
        check_val("mid_rst/calc_done", 32'(calc_done), 0);
        check_val("mid_rst/damage", 32'(damage), 0);
        check_state("mid_rst");
        reset_n = 1'b1;
        do_calc(0, 0);

        // Randomized battles.
        for (int it = 0; it < 30; it++) begin
            int tr;
            tr = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1) load_move($urandom_range(0, 3));
            for (int w = $urandom_range(0, 3); w > 0; w--) tick();
            do_calc(tr, $urandom_range(0, 1));
            do_apply($urandom_range(0, 1), $urandom_range(1, 3));
            if (it % 7 == 6) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
